// File: rtl/ecc_pkg.sv
// Shared types and constants for the Hamming ECC controller and datapath.
package ecc_pkg;

    // Operation encoding carried on ctrl_op.
    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_FULL = 2'd2,
        OP_ILL  = 2'd3
    } op_e;

    // Codeword width encoding carried on ctrl_width / width_sel.
    typedef enum logic [1:0] {
        W8    = 2'd0,
        W16   = 2'd1,
        W32   = 2'd2,
        W_ILL = 2'd3
    } width_e;

    // Sequencing controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_NOISE = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Payload bits carried by each codeword width.
    localparam int DATA_BITS_W8  = 4;
    localparam int DATA_BITS_W16 = 11;
    localparam int DATA_BITS_W32 = 26;

    // Check bits (Hamming plus overall parity) for each codeword width.
    localparam int PARITY_BITS_W8  = 4;
    localparam int PARITY_BITS_W16 = 5;
    localparam int PARITY_BITS_W32 = 6;

    // Payload bit count for a given width code; 0 for the illegal code.
    function automatic int data_bits(input width_e w);
        case (w)
            W8:      data_bits = DATA_BITS_W8;
            W16:     data_bits = DATA_BITS_W16;
            W32:     data_bits = DATA_BITS_W32;
            default: data_bits = 0;
        endcase
    endfunction

    // Check bit count for a given width code; 0 for the illegal code.
    function automatic int parity_bits(input width_e w);
        case (w)
            W8:      parity_bits = PARITY_BITS_W8;
            W16:     parity_bits = PARITY_BITS_W16;
            W32:     parity_bits = PARITY_BITS_W32;
            default: parity_bits = 0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_op_ctrl.sv
// Sequencing controller for the Hamming ECC datapath. Accepts one command
// (encode, decode, or encode->noise->decode), issues one-cycle load strobes
// to the datapath, and reports completion, error count and illegal status.
module ecc_op_ctrl
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           ctrl_op,
    input  logic [1:0]           ctrl_width,
    input  logic [1:0]           dec_num_err,
    output logic [1:0]           width_sel,
    output logic                 dec_src_sel,
    output logic                 enc_ld,
    output logic                 noise_ld,
    output logic                 dec_ld,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           num_of_errors,
    output logic                 err_illegal,
    output logic [CNT_WIDTH-1:0] op_cnt
);

    // Widest legal width code; codes above it are rejected as illegal.
    localparam logic [1:0] MAX_W_CODE = (DATA_WIDTH >= 32) ? 2'(W32) :
                                        (DATA_WIDTH >= 16) ? 2'(W16) : 2'(W8);

    ctrl_state_e          state_q, state_d;
    op_e                  op_q, op_d;
    logic [1:0]           width_sel_q, width_sel_d;
    logic                 dec_src_sel_q, dec_src_sel_d;
    logic                 enc_ld_q, enc_ld_d;
    logic                 noise_ld_q, noise_ld_d;
    logic                 dec_ld_q, dec_ld_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           num_err_q, num_err_d;
    logic                 err_ill_q, err_ill_d;
    logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;
    logic                 cmd_illegal;

    // Next-state, command latch and registered (Moore) output decode.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        width_sel_d   = width_sel_q;
        dec_src_sel_d = dec_src_sel_q;
        num_err_d     = num_err_q;
        err_ill_d     = err_ill_q;
        op_cnt_d      = op_cnt_q;
        cmd_illegal   = (op_e'(ctrl_op) == OP_ILL) || (ctrl_width > MAX_W_CODE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d          = op_e'(ctrl_op);
                    width_sel_d   = ctrl_width;
                    dec_src_sel_d = 1'b0;
                    num_err_d     = 2'd0;
                    err_ill_d     = 1'b0;
                    if (cmd_illegal) begin
                        err_ill_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        case (op_e'(ctrl_op))
                            OP_DEC:  state_d = ST_DEC;
                            OP_FULL: begin
                                state_d       = ST_ENC;
                                dec_src_sel_d = 1'b1;
                            end
                            default: state_d = ST_ENC;
                        endcase
                    end
                end
            end
            ST_ENC:   state_d = (op_q == OP_FULL) ? ST_NOISE : ST_DONE;
            ST_NOISE: state_d = ST_DEC;
            ST_DEC: begin
                // Code 3 is not a valid decoder result; report it as double error.
                num_err_d = (dec_num_err == 2'd3) ? 2'd2 : dec_num_err;
                state_d   = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they belong to.
        enc_ld_d   = (state_d == ST_ENC);
        noise_ld_d = (state_d == ST_NOISE);
        dec_ld_d   = (state_d == ST_DEC);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);

        // Count the operation as it enters DONE so the new count is visible with done.
        if ((state_d == ST_DONE) && (op_cnt_q != {CNT_WIDTH{1'b1}})) begin
            op_cnt_d = op_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Single state/output register bank; reset aborts any operation immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_ENC;
            width_sel_q   <= 2'd0;
            dec_src_sel_q <= 1'b0;
            enc_ld_q      <= 1'b0;
            noise_ld_q    <= 1'b0;
            dec_ld_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            num_err_q     <= 2'd0;
            err_ill_q     <= 1'b0;
            op_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            width_sel_q   <= width_sel_d;
            dec_src_sel_q <= dec_src_sel_d;
            enc_ld_q      <= enc_ld_d;
            noise_ld_q    <= noise_ld_d;
            dec_ld_q      <= dec_ld_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            num_err_q     <= num_err_d;
            err_ill_q     <= err_ill_d;
            op_cnt_q      <= op_cnt_d;
        end
    end

    assign width_sel     = width_sel_q;
    assign dec_src_sel   = dec_src_sel_q;
    assign enc_ld        = enc_ld_q;
    assign noise_ld      = noise_ld_q;
    assign dec_ld        = dec_ld_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign num_of_errors = num_err_q;
    assign err_illegal   = err_ill_q;
    assign op_cnt        = op_cnt_q;

endmodule

// File: tb/tb_ecc_op_ctrl.sv
// Scoreboard bench for ecc_op_ctrl: the driver pushes the expected outcome
// of each accepted command, the monitor pops it when done is seen.
module tb_ecc_op_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] ctrl_op = 2'd0;
    logic [1:0] ctrl_width = 2'd0;
    logic [1:0] dec_num_err = 2'd0;
    logic [1:0] width_sel;
    logic       dec_src_sel;
    logic       enc_ld;
    logic       noise_ld;
    logic       dec_ld;
    logic       busy;
    logic       done;
    logic [1:0] num_of_errors;
    logic       err_illegal;
    logic [7:0] op_cnt;

    ecc_op_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl_op(ctrl_op),
        .ctrl_width(ctrl_width), .dec_num_err(dec_num_err),
        .width_sel(width_sel), .dec_src_sel(dec_src_sel), .enc_ld(enc_ld),
        .noise_ld(noise_ld), .dec_ld(dec_ld), .busy(busy), .done(done),
        .num_of_errors(num_of_errors), .err_illegal(err_illegal), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        int         lat;
        bit         full;
        bit         has_enc;
        bit         has_dec;
        int         nerr;
        bit         ill;
        int         wsel;
        bit         src;
        int         cnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cnt_model = 0;

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int all_outs();
        logic [18:0] v;
        v = {width_sel, dec_src_sel, enc_ld, noise_ld, dec_ld, busy, done,
             num_of_errors, err_illegal, op_cnt};
        return int'(v);
    endfunction

    // Drive start for one cycle at the current negedge; exp_ne is the hand-computed error report.
    task automatic issue(input logic [1:0] op, input logic [1:0] w,
                         input logic [1:0] ne, input int exp_ne);
        exp_t e;
        bit   ill;
        ill         = (op == 2'd3) || (w == 2'd3);
        start       = 1'b1;
        ctrl_op     = op;
        ctrl_width  = w;
        dec_num_err = ne;
        e.t       = cyc;
        e.ill     = ill;
        e.full    = !ill && (op == 2'd2);
        e.has_enc = !ill && (op == 2'd0 || op == 2'd2);
        e.has_dec = !ill && (op == 2'd1 || op == 2'd2);
        e.lat     = ill ? 1 : ((op == 2'd2) ? 4 : 2);
        e.nerr    = exp_ne;
        e.wsel    = int'(w);
        e.src     = e.full;
        if (cnt_model < 255) cnt_model++;
        e.cnt     = cnt_model;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: track strobes/busy per operation and score each done against the queue.
    int   enc_at = -1, noise_at = -1, dec_at = -1;
    int   n_enc = 0, n_noise = 0, n_dec = 0, busy_n = 0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            enc_at = -1; noise_at = -1; dec_at = -1;
            n_enc = 0; n_noise = 0; n_dec = 0; busy_n = 0;
        end else begin
            if (enc_ld)   begin n_enc++;   enc_at = cyc;   end
            if (noise_ld) begin n_noise++; noise_at = cyc; end
            if (dec_ld)   begin n_dec++;   dec_at = cyc;   end
            if (busy) busy_n++;
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    me = sbq.pop_front();
                    check("done_time", cyc, me.t + me.lat);
                    check("busy_cycles", busy_n, me.lat);
                    check("enc_ld_count", n_enc, int'(me.has_enc));
                    if (me.has_enc) check("enc_ld_time", enc_at, me.t + 1);
                    check("noise_ld_count", n_noise, int'(me.full));
                    if (me.full) check("noise_ld_time", noise_at, me.t + 2);
                    check("dec_ld_count", n_dec, int'(me.has_dec));
                    if (me.has_dec) check("dec_ld_time", dec_at, me.t + (me.full ? 3 : 1));
                    check("num_of_errors", int'(num_of_errors), me.nerr);
                    check("err_illegal", int'(err_illegal), int'(me.ill));
                    check("width_sel", int'(width_sel), me.wsel);
                    check("dec_src_sel", int'(dec_src_sel), int'(me.src));
                    check("op_cnt", int'(op_cnt), me.cnt);
                end
                enc_at = -1; noise_at = -1; dec_at = -1;
                n_enc = 0; n_noise = 0; n_dec = 0; busy_n = 0;
            end
        end
    end

    initial begin
        int waited;
        // Reset, then idle with everything at zero.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", all_outs(), 0);
        end

        // Full channel, 32-bit, single error.
        issue(2'd2, 2'd2, 2'd1, 1);
        repeat (6) @(negedge clk);
        check("width_sel_hold_idle", int'(width_sel), 2);
        check("dec_src_sel_hold_idle", int'(dec_src_sel), 1);

        // Encode 8-bit; decode 16-bit double error; decode with code 3.
        issue(2'd0, 2'd0, 2'd0, 0);
        repeat (3) @(negedge clk);
        issue(2'd1, 2'd1, 2'd2, 2);
        repeat (3) @(negedge clk);
        issue(2'd1, 2'd0, 2'd3, 2);
        repeat (3) @(negedge clk);

        // Illegal width, illegal op, then a legal op clears err_illegal.
        issue(2'd0, 2'd3, 2'd0, 0);
        repeat (2) @(negedge clk);
        check("err_illegal_hold", int'(err_illegal), 1);
        issue(2'd3, 2'd1, 2'd2, 0);
        repeat (2) @(negedge clk);
        issue(2'd0, 2'd1, 2'd0, 0);
        check("err_illegal_clear", int'(err_illegal), 0);
        repeat (3) @(negedge clk);

        // Starts during a full op are ignored; start right after DONE is accepted.
        issue(2'd2, 2'd1, 2'd2, 2);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(2'd0, 2'd2, 2'd0, 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a full op.
        start = 1'b1; ctrl_op = 2'd2; ctrl_width = 2'd2; dec_num_err = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs_a", all_outs(), 0);
        @(negedge clk);
        check("abort_outputs_b", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_model = 0;
        repeat (6) @(negedge clk);
        check("abort_op_cnt", int'(op_cnt), 0);

        // Back-to-back encodes until the counter saturates.
        for (int i = 0; i < 300; i++) begin
            issue(2'd0, 2'(i % 3), 2'd0, 0);
            repeat (2) @(negedge clk);
        end

        waited = 0;
        while (sbq.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drain", sbq.size(), 0);
        check("op_cnt_saturated", int'(op_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_op_ctrl.md
Name: ecc_op_ctrl

Overview:
- Sequencing controller for the Hamming ECC datapath: encoders for 8/16/32-bit codewords, noise injection, decoder.
- Accepts one operation command (encode, decode, or full channel = encode -> add noise -> decode) and steps the datapath through it with one-cycle load strobes.
- Reports completion, error count and illegal-command status, and keeps a count of completed operations.
- Sits between the register/bus front-end and the ECC datapath.

Parameters:
- DATA_WIDTH, 32, widest codeword in bits; fixes the supported width set 8/16/32.
- CNT_WIDTH, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command request; sampled only in IDLE.
- ctrl_op  in  2  operation: 0 = encode, 1 = decode, 2 = full channel, 3 = illegal.
- ctrl_width  in  2  codeword width: 0 = 8, 1 = 16, 2 = 32, 3 = illegal.
- dec_num_err  in  2  decoder result: 0 = no error, 1 = single corrected, 2 = double detected.
- width_sel  out  2  registered width to the datapath muxes; held for the whole operation.
- dec_src_sel  out  1  decoder input source: 0 = external data, 1 = noisy codeword register.
- enc_ld  out  1  capture encoder output into the codeword register.
- noise_ld  out  1  codeword register <= codeword register XOR noise.
- dec_ld  out  1  capture decoder output and dec_num_err.
- busy  out  1  high from the cycle after an accepted start until DONE, inclusive.
- done  out  1  one-cycle pulse in DONE.
- num_of_errors  out  2  error count of the last operation.
- err_illegal  out  1  last command was illegal.
- op_cnt  out  CNT_WIDTH  completed operations; saturating.

Behaviour:
- Reset: state IDLE; every output is 0; op_cnt is 0. A reset in any state aborts the operation in the same edge and leaves no strobe or done pending.
- States: IDLE, ENC, NOISE, DEC, DONE.
- IDLE, start = 1: latch ctrl_op and ctrl_width into width_sel and the internal op register, then go to:
  - ctrl_op or ctrl_width = 3 -> DONE with err_illegal = 1; no strobes in this operation.
  - encode -> ENC.
  - decode -> DEC with dec_src_sel = 0.
  - full -> ENC with dec_src_sel = 1.
- ENC: enc_ld = 1. Next state is DONE for encode, NOISE for full.
- NOISE: noise_ld = 1 -> DEC.
- DEC: dec_ld = 1; num_of_errors <= dec_num_err in this cycle -> DONE.
- DONE: done = 1; op_cnt increments, saturating at all-ones -> IDLE.
- Strobes are Moore outputs, exactly one cycle each, one state per cycle.
- Latency from the start cycle T: encode done at T+2; decode done at T+2; full done at T+4; illegal done at T+1.
- num_of_errors and err_illegal clear to 0 when a new start is accepted, update during the operation, and then hold until the next accepted start. Encode and illegal ops report num_of_errors = 0.
- dec_num_err = 3 is treated as 2.
- start while busy is ignored. No queuing; start is not accepted in DONE.
- width_sel and dec_src_sel are stable from T+1 through DONE and keep their value in IDLE.
- A start in the cycle after DONE (back to IDLE) is accepted normally.

Decomposition:
- Shared package ecc_pkg holds:
  - enums op_e (OP_ENC, OP_DEC, OP_FULL, OP_ILL) and width_e (W8, W16, W32, W_ILL);
  - enum ctrl_state_e;
  - constants for data bits per width (4/11/26) and parity bits per width (4/5/6) for datapath reuse.
- Single module. The FSM and the output/counter registers stay together; no sub-module.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, op_cnt = 0, no strobes.
- Start, op = 2, width = 2, dec_num_err = 1 -> enc_ld at T+1, noise_ld at T+2, dec_ld at T+3, done at T+4 with num_of_errors = 1; busy high T+1..T+4; width_sel = 2; dec_src_sel = 1; op_cnt = 1.
- Start, op = 0, width = 0 -> enc_ld at T+1, done at T+2, num_of_errors = 0. Start, op = 1, width = 1, dec_num_err = 2 -> dec_ld at T+1, done at T+2, num_of_errors = 2, dec_src_sel = 0.
- Start with width = 3, and separately with op = 3 -> done at T+1, err_illegal = 1, no enc_ld/noise_ld/dec_ld. Next legal start clears err_illegal.
- Start pulses at T+1..T+3 during a full op -> ignored, single done; a start at T+5 is accepted.
- rst asserted at T+2 of a full op -> IDLE next edge, no done, outputs 0. Then 300 encode ops -> op_cnt saturates at 255.
